hwag_spi_tx_data_frame: RTL and testbench

HWAG_SPI_TX_DATA_FRAME -- requirements
Module: hwag_spi_tx_data_frame

---
 rtl/hwag_spi_tx_data_frame.sv | 169 ++++++++++++++++
 tb/tb_hwag_spi_tx_data_frame.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_spi_tx_data_frame.sv
`default_nettype none
// ============================================================================
// Module   : hwag_spi_tx_data_frame
// Purpose  : Builds the CMD/ADDR/DATA32/CRC8 response frame for an SPI slave.
// Revision : 1.0
// ============================================================================
module hwag_spi_tx_data_frame #(
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ss,
    input  logic        spi_tx,
    input  logic [7:0]  tx_cmd,
    input  logic [7:0]  tx_addr,
    input  logic [31:0] tx_data,
    output logic [7:0]  bus_in,
    output logic [7:0]  crc_tx_out,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte 6 of the frame is the CRC; indices 0..5 are shadow bytes.
    localparam logic [2:0] c_CRC_IDX = 3'd6;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ss_q;
    logic        r_ss_armed;
    logic [47:0] r_shadow;
    logic [47:0] w_shadow_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [2:0]  w_idx_inc;
    logic [7:0]  r_bus_in;
    logic [7:0]  w_bus_in_nxt;
    logic [7:0]  r_crc;
    logic [7:0]  w_crc_nxt;
    logic [7:0]  w_crc_fold;
    logic [7:0]  w_next_byte;
    logic        r_overrun;
    logic        w_overrun_nxt;
    logic        r_frame_done;
    logic        w_frame_done_nxt;
    logic        r_aborted;
    logic        w_aborted_nxt;
    logic        w_ss_fall;
    logic        w_ss_rise;
    logic [7:0]  w_shadow_bytes [0:5];

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    // A fall only counts once spi_ss has been seen high since reset, so a
    // select line held low through reset never opens a frame.
    assign w_ss_fall  = r_ss_armed & r_ss_q & ~spi_ss;
    assign w_ss_rise  = ~r_ss_q & spi_ss;
    assign w_crc_fold = crc8_byte(r_crc, r_bus_in);
    assign w_idx_inc  = r_idx + 3'd1;

    for (genvar k = 0; k < 6; k++) begin : g_shadow_bytes
        assign w_shadow_bytes[k] = r_shadow[47-8*k -: 8];
    end

    always_comb begin
        w_next_byte = 8'h00;
        if (r_idx < 3'd5) begin
            w_next_byte = w_shadow_bytes[w_idx_inc];
        end else if (r_idx == 3'd5) begin
            w_next_byte = w_crc_fold;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shadow_nxt     = r_shadow;
        w_idx_nxt        = r_idx;
        w_bus_in_nxt     = r_bus_in;
        w_crc_nxt        = r_crc;
        w_overrun_nxt    = r_overrun;
        w_frame_done_nxt = 1'b0;
        w_aborted_nxt    = 1'b0;

        // Select edges take priority over a coincident spi_tx.
        if (w_ss_fall) begin
            w_state_nxt   = ST_SEND;
            w_shadow_nxt  = {tx_cmd, tx_addr, tx_data};
            w_idx_nxt     = 3'd0;
            w_crc_nxt     = CRC_INIT;
            w_overrun_nxt = 1'b0;
            w_bus_in_nxt  = tx_cmd;
        end else if (w_ss_rise) begin
            w_aborted_nxt = (r_state == ST_SEND);
            w_state_nxt   = ST_IDLE;
            w_bus_in_nxt  = 8'h00;
        end else if (spi_tx) begin
            case (r_state)
                ST_SEND: begin
                    if (r_idx == c_CRC_IDX) begin
                        // The CRC byte itself is never folded into the CRC.
                        w_state_nxt      = ST_DONE;
                        w_bus_in_nxt     = 8'h00;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_crc_nxt    = w_crc_fold;
                        w_idx_nxt    = w_idx_inc;
                        w_bus_in_nxt = w_next_byte;
                    end
                end
                ST_DONE: begin
                    w_overrun_nxt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ss_q       <= 1'b1;
            r_ss_armed   <= 1'b0;
            r_shadow     <= 48'd0;
            r_idx        <= 3'd0;
            r_bus_in     <= 8'h00;
            r_crc        <= 8'h00;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ss_q       <= spi_ss;
            r_ss_armed   <= r_ss_armed | spi_ss;
            r_shadow     <= w_shadow_nxt;
            r_idx        <= w_idx_nxt;
            r_bus_in     <= w_bus_in_nxt;
            r_crc        <= w_crc_nxt;
            r_overrun    <= w_overrun_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    assign bus_in     = r_bus_in;
    assign crc_tx_out = r_crc;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign aborted    = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_hwag_spi_tx_data_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_spi_tx_data_frame
// Purpose  : Self-checking bench for hwag_spi_tx_data_frame.
// Revision : 1.0
// ============================================================================
module tb_hwag_spi_tx_data_frame;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_ss;
    logic        spi_tx;
    logic [7:0]  tx_cmd;
    logic [7:0]  tx_addr;
    logic [31:0] tx_data;
    wire  [7:0]  bus_in;
    wire  [7:0]  crc_tx_out;
    wire         busy;
    wire         frame_done;
    wire         overrun;
    wire         aborted;

    int          passed = 0;
    int          total = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp;
    logic [7:0]  frame_crc;

    hwag_spi_tx_data_frame #(
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_ss     (spi_ss),
        .spi_tx     (spi_tx),
        .tx_cmd     (tx_cmd),
        .tx_addr    (tx_addr),
        .tx_data    (tx_data),
        .bus_in     (bus_in),
        .crc_tx_out (crc_tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    // Bit-serial reference CRC: feedback = top CRC bit XOR next message bit.
    function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_done) done_cnt++;
        if (aborted) abort_cnt++;
    endtask

    task automatic pulse();
        spi_tx = 1'b1;
        step();
        spi_tx = 1'b0;
    endtask

    // Pushes the seven expected bytes and opens the frame with a select fall.
    task automatic start_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] bytes [0:5];
        logic [7:0] crc;
        bytes[0] = c; bytes[1] = a;
        bytes[2] = d[31:24]; bytes[3] = d[23:16]; bytes[4] = d[15:8]; bytes[5] = d[7:0];
        crc = CRC_INIT;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(bytes[i]);
            crc = crc_model(crc, bytes[i]);
        end
        exp_q.push_back(crc);
        frame_crc = crc;
        tx_cmd = c; tx_addr = a; tx_data = d;
        spi_ss = 1'b0;
        step();
    endtask

    task automatic end_frame();
        spi_ss = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_ss = 1'b1; spi_tx = 1'b0;
        tx_cmd = 8'h00; tx_addr = 8'h00; tx_data = 32'h0;
        step(); step(); step();
        total++; if (bus_in !== 8'h00) $display("FAIL reset_bus_in: got %h want 00", bus_in); else passed++;
        total++; if (crc_tx_out !== 8'h00) $display("FAIL reset_crc: got %h want 00", crc_tx_out); else passed++;
        total++; if ({busy, frame_done, overrun, aborted} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy, frame_done, overrun, aborted}); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        int d0;
        d0 = done_cnt;
        start_frame(8'hA5, 8'h3C, 32'h12345678);
        total++; if (busy !== 1'b1) $display("FAIL nominal_busy_start: got %b want 1", busy); else passed++;
        for (int i = 0; i < 7; i++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (bus_in !== exp) $display("FAIL nominal_byte%0d: got %h want %h", i, bus_in, exp); else passed++;
            pulse();
        end
        total++; if (frame_done !== 1'b1) $display("FAIL nominal_done_pulse: got %b want 1", frame_done); else passed++;
        total++; if (crc_tx_out !== frame_crc) $display("FAIL nominal_crc_hold: got %h want %h", crc_tx_out, frame_crc); else passed++;
        step(); step(); step();
        total++; if (done_cnt !== d0 + 1) $display("FAIL nominal_done_count: got %0d want %0d", done_cnt, d0 + 1); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL nominal_busy_done: got %b want 1", busy); else passed++;
        total++; if (bus_in !== 8'h00) $display("FAIL nominal_done_bus: got %h want 00", bus_in); else passed++;
        spi_ss = 1'b1;
        step();
        total++; if (busy !== 1'b0) $display("FAIL nominal_busy_end: got %b want 0", busy); else passed++;
        step();
    endtask

    task automatic test_crc_edges();
        logic [31:0] datas [0:1];
        logic [7:0]  crcs [0:1];
        datas[0] = 32'h00000000; crcs[0] = 8'h00;
        datas[1] = 32'h00000001; crcs[1] = 8'h07;
        for (int f = 0; f < 2; f++) begin
            start_frame(8'h00, 8'h00, datas[f]);
            for (int i = 0; i < 7; i++) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                total++; if (bus_in !== exp) $display("FAIL crc_edge%0d_byte%0d: got %h want %h", f, i, bus_in, exp); else passed++;
                if (i == 6) begin
                    total++; if (bus_in !== crcs[f]) $display("FAIL crc_edge%0d_const: got %h want %h", f, bus_in, crcs[f]); else passed++;
                end
                pulse();
            end
            end_frame();
        end
    endtask

    task automatic test_abort();
        int d0;
        int a0;
        d0 = done_cnt; a0 = abort_cnt;
        start_frame(8'h11, 8'h22, 32'h33445566);
        for (int i = 0; i < 3; i++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (bus_in !== exp) $display("FAIL abort_byte%0d: got %h want %h", i, bus_in, exp); else passed++;
            pulse();
        end
        spi_ss = 1'b1;
        step();
        total++; if (aborted !== 1'b1) $display("FAIL abort_pulse: got %b want 1", aborted); else passed++;
        step();
        total++; if ({busy, bus_in} !== 9'h000) $display("FAIL abort_idle: got busy=%b bus=%h want 0/00", busy, bus_in); else passed++;
        total++; if (abort_cnt !== a0 + 1 || done_cnt !== d0)
            $display("FAIL abort_counts: got abort=%0d done=%0d want %0d/%0d", abort_cnt, done_cnt, a0 + 1, d0); else passed++;
        start_frame(8'h11, 8'h22, 32'h33445566);
        for (int i = 0; i < 7; i++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (bus_in !== exp) $display("FAIL abort_restart_byte%0d: got %h want %h", i, bus_in, exp); else passed++;
            pulse();
        end
        end_frame();
    endtask

    task automatic test_overrun();
        int a0;
        start_frame(8'h9C, 8'h01, 32'hDEADBEEF);
        for (int i = 0; i < 7; i++) pulse();
        total++; if (overrun !== 1'b0) $display("FAIL overrun_before: got %b want 0", overrun); else passed++;
        pulse();
        total++; if (overrun !== 1'b1 || bus_in !== 8'h00)
            $display("FAIL overrun_set: got ovr=%b bus=%h want 1/00", overrun, bus_in); else passed++;
        a0 = abort_cnt;
        end_frame();
        total++; if (overrun !== 1'b1 || abort_cnt !== a0)
            $display("FAIL overrun_sticky: got ovr=%b aborts=%0d want 1/%0d", overrun, abort_cnt, a0); else passed++;
        start_frame(8'h9C, 8'h01, 32'hDEADBEEF);
        total++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun); else passed++;
        end_frame();
    endtask

    task automatic test_snapshot();
        start_frame(8'h5A, 8'hC3, 32'hCAFEBABE);
        tx_data = 32'hFFFFFFFF; tx_cmd = 8'hFF; tx_addr = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (bus_in !== exp) $display("FAIL snapshot_byte%0d: got %h want %h", i, bus_in, exp); else passed++;
            pulse();
        end
        end_frame();
    endtask

    task automatic test_collision();
        logic [7:0] crc2;
        crc2 = crc_model(crc_model(CRC_INIT, 8'h81), 8'h42);
        start_frame(8'h81, 8'h42, 32'h0F0F0F0F);
        pulse();
        pulse();
        spi_tx = 1'b1; spi_ss = 1'b1;
        step();
        spi_tx = 1'b0;
        total++; if (aborted !== 1'b1) $display("FAIL collision_abort: got %b want 1", aborted); else passed++;
        total++; if (crc_tx_out !== crc2) $display("FAIL collision_crc: got %h want %h", crc_tx_out, crc2); else passed++;
        total++; if ({busy, bus_in} !== 9'h000) $display("FAIL collision_idle: got busy=%b bus=%h want 0/00", busy, bus_in); else passed++;
        step();
    endtask

    task automatic test_reset_midframe();
        int d0;
        int a0;
        start_frame(8'h77, 8'h66, 32'h55443322);
        pulse();
        pulse();
        d0 = done_cnt; a0 = abort_cnt;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if ({busy, bus_in} !== 9'h000) $display("FAIL rstmid_idle%0d: got busy=%b bus=%h want 0/00", i, busy, bus_in); else passed++;
        end
        total++; if (done_cnt !== d0 || abort_cnt !== a0)
            $display("FAIL rstmid_pulses: got done=%0d abort=%0d want %0d/%0d", done_cnt, abort_cnt, d0, a0); else passed++;
        spi_ss = 1'b1;
        step();
        start_frame(8'h77, 8'h66, 32'h55443322);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (bus_in !== exp || busy !== 1'b1)
            $display("FAIL rstmid_restart: got bus=%h busy=%b want %h/1", bus_in, busy, exp); else passed++;
        end_frame();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_crc_edges();
        test_abort();
        test_overrun();
        test_snapshot();
        test_collision();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
